// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and default
// receive parameters.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  localparam int unsigned DEF_LOCK_RUN       = 8;
  localparam int unsigned DEF_SEARCH_TIMEOUT = 2048;
  localparam int unsigned DEF_BITSLIP_WAIT   = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

endpackage

// File: rtl/tmds_word_decoder.sv
// Combinational TMDS 10b word decode into data-enable, control pair and
// pixel byte.
module tmds_word_decoder
  import tmds_pkg::*;
(
  input  logic [9:0] tmds_word,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    de   = 1'b0;
    ctrl = '0;
    data = '0;
    d    = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];
    case (tmds_word)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default: begin
        de        = 1'b1;
        data[0]   = d[0];
        // bit 8 selects XOR vs XNOR chaining used by the transmitter
        data[7:1] = tmds_word[8] ? (d[7:1] ^ d[6:0]) : ~(d[7:1] ^ d[6:0]);
      end
    endcase
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS data channel receiver: word alignment by control-token hunting with
// bitslip, then two-stage decode to video data or control values.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN       = DEF_LOCK_RUN,
  parameter int unsigned SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
  parameter int unsigned BITSLIP_WAIT   = DEF_BITSLIP_WAIT
) (
  input  logic       I_pix_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds_word,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic [3:0] O_slip_count,
  output logic       O_de,
  output logic [1:0] O_ctrl,
  output logic [7:0] O_data
);

  localparam int unsigned TO_W   = ($clog2(SEARCH_TIMEOUT) > 12) ? $clog2(SEARCH_TIMEOUT) : 12;
  localparam int unsigned WAIT_W = (BITSLIP_WAIT > 1) ? $clog2(BITSLIP_WAIT) : 1;

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BITSLIP_WAIT - 1);
  localparam logic [7:0]        RUN_FULL  = 8'(LOCK_RUN);

  align_state_t      state;
  logic [9:0]        w1;
  logic [7:0]        run_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic       dec_de;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;
  logic       token;

  tmds_word_decoder u_dec (
    .tmds_word (w1),
    .de        (dec_de),
    .ctrl      (dec_ctrl),
    .data      (dec_data)
  );

  assign token     = ~dec_de;
  assign O_bitslip = (state == ST_SLIP);
  assign O_locked  = (state == ST_LOCKED);

  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      state        <= ST_SEARCH;
      w1           <= '0;
      run_cnt      <= '0;
      to_cnt       <= '0;
      wait_cnt     <= '0;
      O_slip_count <= '0;
      O_de         <= 1'b0;
      O_ctrl       <= '0;
      O_data       <= '0;
    end else begin
      w1 <= I_tmds_word;

      if (!O_locked) begin
        O_de   <= 1'b0;
        O_ctrl <= '0;
        O_data <= '0;
      end else begin
        O_de   <= dec_de;
        O_data <= dec_data;
        if (!dec_de) O_ctrl <= dec_ctrl;
      end

      if (state == ST_WAIT || !token) run_cnt <= '0;
      else if (run_cnt != RUN_FULL)   run_cnt <= run_cnt + 8'd1;

      case (state)
        ST_SEARCH: begin
          // a completed token run takes priority over an expiring search
          if (run_cnt == RUN_FULL) begin
            state  <= ST_LOCKED;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= ST_SLIP;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_SLIP: begin
          O_slip_count <= (O_slip_count == 4'd9) ? 4'd0 : O_slip_count + 4'd1;
          wait_cnt     <= '0;
          to_cnt       <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          to_cnt <= '0;
          if (wait_cnt == WAIT_LAST) state    <= ST_SEARCH;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        ST_LOCKED: begin
          if (run_cnt == RUN_FULL) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state   <= ST_SEARCH;
            to_cnt  <= '0;
            run_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed-vector bench for tmds_channel_rx with a short search timeout so
// slip, lock and lock-loss sequences fit in a few hundred cycles.
module tb_tmds_channel_rx;

  logic       clk;
  logic       rst_n;
  logic [9:0] tmds_word;
  logic       bitslip;
  logic       locked;
  logic [3:0] slip_count;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;

  int total;
  int bad;

  tmds_channel_rx #(
    .LOCK_RUN       (8),
    .SEARCH_TIMEOUT (32),
    .BITSLIP_WAIT   (4)
  ) dut (
    .I_pix_clk    (clk),
    .I_rst_n      (rst_n),
    .I_tmds_word  (tmds_word),
    .O_bitslip    (bitslip),
    .O_locked     (locked),
    .O_slip_count (slip_count),
    .O_de         (de),
    .O_ctrl       (ctrl),
    .O_data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int unsigned k);
    logic [19:0] dbl;
    dbl = {w, w};
    return dbl[k +: 10];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(10'h354);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] all_out;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(10'($urandom_range(1023)));
      all_out = {bitslip, locked, slip_count, de, ctrl, data};
      total++;
      if (all_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0000", i, all_out);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_blanking();
    int pulses;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(10'h354);
      if (bitslip) pulses++;
      if (k == 9) begin
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: locked=%b expected 0", locked); end
      end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_rise: locked=%b expected 1", locked); end
    step(10'h354);
    total++;
    if ({de, ctrl, data} !== 11'h000) begin
      bad++; $display("FAIL blank_00: de=%b ctrl=%b data=%h expected 0/00/00", de, ctrl, data);
    end
    step(10'h2AB);
    step(10'h2AB);
    total++;
    if (de !== 1'b0 || ctrl !== 2'b11 || data !== 8'h00) begin
      bad++; $display("FAIL blank_11: de=%b ctrl=%b data=%h expected 0/11/00", de, ctrl, data);
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL blank_no_slip: pulses=%0d expected 0", pulses); end
  endtask

  task automatic test_video_decode();
    logic [9:0] vec [4];
    logic [7:0] exp_data [3];
    vec[0] = 10'h100; vec[1] = 10'h3FF; vec[2] = 10'h1FF; vec[3] = 10'h354;
    exp_data[0] = 8'h00; exp_data[1] = 8'h00; exp_data[2] = 8'h01;
    step(vec[0]);
    for (int i = 0; i < 3; i++) begin
      step(vec[i+1]);
      total++;
      if (de !== 1'b1 || data !== exp_data[i] || ctrl !== 2'b11) begin
        bad++;
        $display("FAIL video_%0d: de=%b ctrl=%b data=%h expected 1/11/%h", i, de, ctrl, data, exp_data[i]);
      end
    end
    step(10'h354);
    total++;
    if (de !== 1'b0 || ctrl !== 2'b00 || data !== 8'h00) begin
      bad++; $display("FAIL video_to_blank: de=%b ctrl=%b data=%h expected 0/00/00", de, ctrl, data);
    end
    for (int i = 0; i < 10; i++) step(10'h354);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL video_keep_lock: locked=%b expected 1", locked); end
  endtask

  task automatic test_lock_loss();
    int pulses;
    pulses = 0;
    for (int k = 1; k <= 66; k++) begin
      step(10'h100);
      if (k < 66 && bitslip) pulses++;
      if (k == 33) begin
        total++;
        if (locked !== 1'b1 || de !== 1'b1) begin
          bad++; $display("FAIL loss_hold: locked=%b de=%b expected 1/1", locked, de);
        end
      end
      if (k == 34) begin
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL loss_fall: locked=%b expected 0", locked); end
      end
      if (k == 35) begin
        total++;
        if (de !== 1'b0 || data !== 8'h00) begin
          bad++; $display("FAIL loss_gate: de=%b data=%h expected 0/00", de, data);
        end
      end
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL loss_no_slip: pulses=%0d expected 0", pulses); end
    total++;
    if (bitslip !== 1'b1) begin bad++; $display("FAIL loss_late_slip: bitslip=%b expected 1", bitslip); end
  endtask

  task automatic test_misalignment();
    int unsigned offset;
    int pulses;
    int lock_step;
    int slip_at [3];
    apply_reset();
    offset = 7;
    pulses = 0;
    lock_step = 0;
    for (int i = 0; i < 3; i++) slip_at[i] = 0;
    for (int n = 1; n <= 160; n++) begin
      step(rot(10'h354, offset));
      if (bitslip) begin
        if (pulses < 3) slip_at[pulses] = n;
        pulses++;
        offset = (offset + 1) % 10;
      end
      if (locked && lock_step == 0) lock_step = n;
    end
    total++;
    if (pulses != 3) begin bad++; $display("FAIL mis_pulses: got %0d expected 3", pulses); end
    total++;
    if (slip_at[0] != 32) begin bad++; $display("FAIL mis_first: step %0d expected 32", slip_at[0]); end
    total++;
    if (slip_at[1] - slip_at[0] != 37 || slip_at[2] - slip_at[1] != 37) begin
      bad++;
      $display("FAIL mis_spacing: gaps %0d,%0d expected 37,37", slip_at[1] - slip_at[0], slip_at[2] - slip_at[1]);
    end
    total++;
    if (lock_step != 120) begin bad++; $display("FAIL mis_lock_step: step %0d expected 120", lock_step); end
    total++;
    if (slip_count !== 4'd3 || locked !== 1'b1) begin
      bad++; $display("FAIL mis_final: slip_count=%0d locked=%b expected 3/1", slip_count, locked);
    end
  endtask

  task automatic test_boundary_lock_vs_timeout();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      step(n <= 22 ? 10'h100 : 10'h354);
      if (bitslip) pulses++;
      if (n == 31) begin
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL bnd_early: locked=%b expected 0", locked); end
      end
      if (n == 32) begin
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL bnd_lock: locked=%b expected 1", locked); end
      end
    end
    total++;
    if (pulses != 0 || slip_count !== 4'd0) begin
      bad++; $display("FAIL bnd_no_slip: pulses=%0d slip_count=%0d expected 0/0", pulses, slip_count);
    end
  endtask

  task automatic test_reset_during_wait();
    int first;
    apply_reset();
    for (int n = 1; n <= 32; n++) step(10'h100);
    total++;
    if (bitslip !== 1'b1) begin bad++; $display("FAIL rw_slip: bitslip=%b expected 1", bitslip); end
    step(10'h100);
    step(10'h100);
    total++;
    if (slip_count !== 4'd1 || bitslip !== 1'b0) begin
      bad++; $display("FAIL rw_in_wait: slip_count=%0d bitslip=%b expected 1/0", slip_count, bitslip);
    end
    rst_n = 1'b0;
    step(10'h100);
    step(10'h100);
    total++;
    if (slip_count !== 4'd0 || bitslip !== 1'b0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL rw_reset: slip_count=%0d bitslip=%b locked=%b expected 0/0/0", slip_count, bitslip, locked);
    end
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      step(10'h100);
      if (bitslip && first == 0) first = n;
    end
    total++;
    if (first != 32) begin bad++; $display("FAIL rw_restart: first pulse step %0d expected 32", first); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    tmds_word = '0;
    test_reset();
    test_aligned_blanking();
    test_video_decode();
    test_lock_loss();
    test_misalignment();
    test_boundary_lock_vs_timeout();
    test_reset_during_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
